// File: rtl/wb_stage_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg : shared constants for the RV32I writeback stage.
//   result_src_e : selects the writeback value (ALU / MEM / PC4)
//   F3_*         : funct3 encodings of the load instructions
// Build macro consumed by this slice: WB_RETIRE_CNT_EN (see wb_stage.sv).
// ----------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_if.sv
// ----------------------------------------------------------------------------
// wb_stage_if : MEM->WB bundle plus the register-file write port and the
// WB->ID bypass.
//   master : MEM stage / environment (drives m_*, observes write port)
//   slave  : wb_stage (captures m_*, drives write port and bypass)
// ----------------------------------------------------------------------------
interface wb_stage_if #(
  parameter int XLEN = 32
) ();

  logic                     m_valid_i;
  logic                     m_reg_write_i;
  logic [4:0]               m_rd_i;
  riscv_pkg::result_src_e   m_result_src_i;
  logic [2:0]               m_funct3_i;
  logic [XLEN-1:0]          m_alu_i;
  logic [XLEN-1:0]          m_rdata_i;
  logic [XLEN-1:0]          m_pc4_i;

  logic                     we3_o;
  logic [4:0]               a3_o;
  logic [XLEN-1:0]          wd3_o;
  logic                     byp_valid_o;
  logic [4:0]               byp_rd_o;
  logic [XLEN-1:0]          byp_data_o;

  modport master (
    output m_valid_i, m_reg_write_i, m_rd_i, m_result_src_i, m_funct3_i,
           m_alu_i, m_rdata_i, m_pc4_i,
    input  we3_o, a3_o, wd3_o, byp_valid_o, byp_rd_o, byp_data_o
  );

  modport slave (
    input  m_valid_i, m_reg_write_i, m_rd_i, m_result_src_i, m_funct3_i,
           m_alu_i, m_rdata_i, m_pc4_i,
    output we3_o, a3_o, wd3_o, byp_valid_o, byp_rd_o, byp_data_o
  );

endinterface

// File: rtl/wb_stage_load_ext.sv
// ----------------------------------------------------------------------------
// load_ext : combinational load alignment and sign/zero extension.
//   funct3_i : load type (LB/LH/LW/LBU/LHU; anything else = whole word)
//   off_i    : byte offset within the word (load address [1:0])
//   word_i   : raw 32-bit memory read word
//   ext_o    : extended value for writeback
// ----------------------------------------------------------------------------
module load_ext
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] ext_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (off_i)
      2'd0:    w_byte = word_i[7:0];
      2'd1:    w_byte = word_i[15:8];
      2'd2:    w_byte = word_i[23:16];
      default: w_byte = word_i[31:24];
    endcase
  end

  // Halfword lane only looks at off[1]; a misaligned off[0] is ignored.
  assign w_half = off_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    ext_o = word_i;
    case (funct3_i)
      F3_LB:   ext_o = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  ext_o = {24'h000000, w_byte};
      F3_LH:   ext_o = {{16{w_half[15]}}, w_half};
      F3_LHU:  ext_o = {16'h0000, w_half};
      default: ext_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage : MEM/WB pipeline register and writeback stage of the RV32I core.
//   clk_i     : core clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   stall_i   : hold the MEM/WB register
//   flush_i   : kill the instruction entering WB (wins over stall)
//   wb        : wb_stage_if.slave - MEM inputs, register-file write port
//               (we3/a3/wd3) and WB->ID bypass
//   instret_o : retired-instruction count
// Build macro WB_RETIRE_CNT_EN: when defined, instret_o is a CNT_W counter
// of edges with a valid WB instruction and no stall; otherwise it is tied 0.
// The register file is not write-first, so ID must use the bypass to see a
// value written in the same cycle.
// ----------------------------------------------------------------------------
module wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             flush_i,
  wb_stage_if.slave        wb,
  output logic [CNT_W-1:0] instret_o
);

  logic              r_valid;
  logic              r_reg_write;
  logic [4:0]        r_rd;
  result_src_e       r_result_src;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_alu;
  logic [XLEN-1:0]   r_rdata;
  logic [XLEN-1:0]   r_pc4;

  logic [31:0]       w_load;
  logic [XLEN-1:0]   w_wd;
  logic              w_we;

  // Flush only needs to clear valid; the payload fields are don't-care and
  // are simply left holding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= 5'd0;
      r_result_src <= RES_ALU;
      r_funct3     <= 3'd0;
      r_alu        <= '0;
      r_rdata      <= '0;
      r_pc4        <= '0;
    end else if (flush_i) begin
      r_valid      <= 1'b0;
    end else if (!stall_i) begin
      r_valid      <= wb.m_valid_i;
      r_reg_write  <= wb.m_reg_write_i;
      r_rd         <= wb.m_rd_i;
      r_result_src <= wb.m_result_src_i;
      r_funct3     <= wb.m_funct3_i;
      r_alu        <= wb.m_alu_i;
      r_rdata      <= wb.m_rdata_i;
      r_pc4        <= wb.m_pc4_i;
    end
  end

  load_ext u_load_ext (
    .funct3_i (r_funct3),
    .off_i    (r_alu[1:0]),
    .word_i   (r_rdata),
    .ext_o    (w_load)
  );

  // Unused encoding 2'b11 falls to the ALU result.
  always_comb begin
    w_wd = r_alu;
    case (r_result_src)
      RES_MEM: w_wd = w_load;
      RES_PC4: w_wd = r_pc4;
      default: w_wd = r_alu;
    endcase
  end

  assign w_we = r_valid & r_reg_write & (r_rd != 5'd0);

  assign wb.we3_o       = w_we;
  assign wb.a3_o        = r_rd;
  assign wb.wd3_o       = w_wd;
  assign wb.byp_valid_o = w_we;
  assign wb.byp_rd_o    = r_rd;
  assign wb.byp_data_o  = w_wd;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_instret;

  // Wraps naturally at the counter width.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_instret <= '0;
    end else if (r_valid && !stall_i) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  assign instret_o = r_instret;
`else
  assign instret_o = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import riscv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [63:0] instret_o;

  int n_vec = 0;
  int n_err = 0;

  wb_stage_if #(.XLEN(32)) u_if ();

  wb_stage #(.XLEN(32), .CNT_W(64)) u_dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .wb        (u_if.slave),
    .instret_o (instret_o)
  );

`ifdef WB_RETIRE_CNT_EN
  // Narrow-counter copy to exercise wrap-around.
  logic [3:0] instret4;
  wb_stage_if #(.XLEN(32)) u_if4 ();
  assign u_if4.m_valid_i      = u_if.m_valid_i;
  assign u_if4.m_reg_write_i  = u_if.m_reg_write_i;
  assign u_if4.m_rd_i         = u_if.m_rd_i;
  assign u_if4.m_result_src_i = u_if.m_result_src_i;
  assign u_if4.m_funct3_i     = u_if.m_funct3_i;
  assign u_if4.m_alu_i        = u_if.m_alu_i;
  assign u_if4.m_rdata_i      = u_if.m_rdata_i;
  assign u_if4.m_pc4_i        = u_if.m_pc4_i;
  wb_stage #(.XLEN(32), .CNT_W(4)) u_dut4 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .wb        (u_if4.slave),
    .instret_o (instret4)
  );
`endif

  always #5 clk_i = ~clk_i;

  // Reference: what the register file should see from the instruction in WB.
  bit              m_valid;
  bit              m_we;
  bit [4:0]        m_rd;
  bit [31:0]       m_wd;
  longint unsigned m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [31:0] ref_load(bit [2:0] f3, bit [31:0] addr, bit [31:0] word);
    int unsigned off = addr % 4;
    int unsigned b   = (word >> (8 * off)) % 256;
    int unsigned h   = (word >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? (32'hFFFF_FF00 + b) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? (32'hFFFF_0000 + h) : h;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic bit [31:0] ref_wd(bit [1:0] src, bit [2:0] f3, bit [31:0] alu,
                                       bit [31:0] rdata, bit [31:0] pc4);
    if (src == 2'd1) return ref_load(f3, alu, rdata);
    if (src == 2'd2) return pc4;
    return alu;
  endfunction

  function automatic logic [63:0] exp_cnt();
`ifdef WB_RETIRE_CNT_EN
    return m_cnt;
`else
    return 64'd0;
`endif
  endfunction

  task automatic drive(bit v, bit rw, bit [4:0] rd, bit [1:0] src, bit [2:0] f3,
                       bit [31:0] alu, bit [31:0] rdata, bit [31:0] pc4,
                       bit st, bit fl);
    u_if.m_valid_i      = v;
    u_if.m_reg_write_i  = rw;
    u_if.m_rd_i         = rd;
    u_if.m_result_src_i = result_src_e'(src);
    u_if.m_funct3_i     = f3;
    u_if.m_alu_i        = alu;
    u_if.m_rdata_i      = rdata;
    u_if.m_pc4_i        = pc4;
    stall_i             = st;
    flush_i             = fl;
  endtask

  task automatic drive_rand(bit st, bit fl);
    drive($urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
          2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, st, fl);
  endtask

  task automatic check_outputs();
    chk("we3", u_if.we3_o, m_we);
    chk("byp_valid", u_if.byp_valid_o, m_we);
    if (m_we) begin
      chk("a3", u_if.a3_o, m_rd);
      chk("wd3", u_if.wd3_o, m_wd);
      chk("byp_rd", u_if.byp_rd_o, m_rd);
      chk("byp_data", u_if.byp_data_o, m_wd);
    end
    chk("instret", instret_o, exp_cnt());
`ifdef WB_RETIRE_CNT_EN
    chk("instret4", instret4, m_cnt % 16);
`endif
  endtask

  // One clock: model follows the edge, outputs are checked at the negedge.
  task automatic step();
    @(posedge clk_i);
    if (m_valid && !stall_i) m_cnt++;
    if (flush_i) begin
      m_valid = 0;
      m_we    = 0;
    end else if (!stall_i) begin
      m_valid = u_if.m_valid_i;
      m_we    = u_if.m_valid_i && u_if.m_reg_write_i && (u_if.m_rd_i != 0);
      m_rd    = u_if.m_rd_i;
      m_wd    = ref_wd(u_if.m_result_src_i, u_if.m_funct3_i, u_if.m_alu_i,
                       u_if.m_rdata_i, u_if.m_pc4_i);
    end
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    drive(1, 1, 5'($urandom_range(1, 31)), 2'($urandom), 3'($urandom),
          $urandom, $urandom, $urandom, 0, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_we3", u_if.we3_o, 1'b0);
    chk("rst_a3", u_if.a3_o, 5'd0);
    chk("rst_wd3", u_if.wd3_o, 32'd0);
    chk("rst_byp_valid", u_if.byp_valid_o, 1'b0);
    chk("rst_byp_rd", u_if.byp_rd_o, 5'd0);
    chk("rst_byp_data", u_if.byp_data_o, 32'd0);
    chk("rst_instret", instret_o, 64'd0);
    m_valid = 0; m_we = 0; m_rd = 0; m_wd = 0; m_cnt = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b1;
  endtask

  initial begin
    do_reset();

    // ALU writeback, then the same with rd = x0.
    drive(1, 1, 5, RES_ALU, F3_LW, 32'h1234_5678, $urandom, $urandom, 0, 0);
    step();
    chk("alu_we3", u_if.we3_o, 1'b1);
    chk("alu_a3", u_if.a3_o, 5'd5);
    chk("alu_wd3", u_if.wd3_o, 32'h1234_5678);
    drive(1, 1, 0, RES_ALU, F3_LW, 32'h1234_5678, $urandom, $urandom, 0, 0);
    step();
    chk("x0_we3", u_if.we3_o, 1'b0);

    // Loads from one fixed memory word.
    drive(1, 1, 9, RES_MEM, F3_LB, 32'h0000_1003, 32'h80FF_7F01, 0, 0, 0);
    step(); chk("lb_off3", u_if.wd3_o, 32'hFFFF_FF80);
    drive(1, 1, 9, RES_MEM, F3_LBU, 32'h0000_1001, 32'h80FF_7F01, 0, 0, 0);
    step(); chk("lbu_off1", u_if.wd3_o, 32'h0000_007F);
    drive(1, 1, 9, RES_MEM, F3_LH, 32'h0000_1002, 32'h80FF_7F01, 0, 0, 0);
    step(); chk("lh_off2", u_if.wd3_o, 32'hFFFF_80FF);
    drive(1, 1, 9, RES_MEM, F3_LHU, 32'h0000_1000, 32'h80FF_7F01, 0, 0, 0);
    step(); chk("lhu_off0", u_if.wd3_o, 32'h0000_7F01);
    drive(1, 1, 9, RES_MEM, F3_LW, 32'h0000_1003, 32'h80FF_7F01, 0, 0, 0);
    step(); chk("lw", u_if.wd3_o, 32'h80FF_7F01);

    // JAL link value.
    drive(1, 1, 1, RES_PC4, F3_LB, $urandom, $urandom, 32'h0000_0104, 0, 0);
    step();
    chk("jal_a3", u_if.a3_o, 5'd1);
    chk("jal_wd3", u_if.wd3_o, 32'h0000_0104);

    // Stall three cycles with fresh inputs, then flush together with stall.
    drive(1, 1, 7, RES_ALU, 0, 32'hCAFE_F00D, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive_rand(1, 0);
      step();
      chk("stall_a3", u_if.a3_o, 5'd7);
      chk("stall_wd3", u_if.wd3_o, 32'hCAFE_F00D);
    end
    drive_rand(1, 1);
    step();
    chk("flush_we3", u_if.we3_o, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive_rand($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      step();
    end

    // Ten retires with a flushed instruction between them.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(1, 1, 5'($urandom_range(1, 31)), 0, 0, $urandom, 0, 0, 0, i == 5);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
`ifdef WB_RETIRE_CNT_EN
    chk("retire10", instret_o, 64'd10);
`else
    chk("retire_off", instret_o, 64'd0);
`endif

    // Seventeen retires: the 4-bit copy wraps to 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, 0, 0, $urandom, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
`ifdef WB_RETIRE_CNT_EN
    chk("retire17_w4", instret4, 4'd1);
    chk("retire17_w64", instret_o, 64'd17);
`else
    chk("retire_off17", instret_o, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
